// File: rtl/sha256_host_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sha256_host_ctrl
//
// Host-side initiator for the SHA-256 core's shared-memory protocol.
// Streams raw message words into word memory at INPUT_ADDR, appends the
// standard SHA-256 padding (0x80000000 marker, zero fill, 64-bit bit length
// whose upper word is always zero here), pulses core_start, waits for the
// core to go busy and then report done, reads the 8 hash words from
// HASH_ADDR and streams them out h0 first.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   go                    one-cycle transaction request (IDLE only)
//   in_valid/in_ready     message word stream, in_data big-endian word order
//   out_valid/out_ready   hash word stream, out_data h0 first, out_last on h7
//   busy                  high whenever a transaction is in progress
//   core_start            one-cycle start pulse to the core
//   core_done             core done level (high while the core is idle)
//   core_input_addr       constant INPUT_ADDR driven to the core
//   core_hash_addr        constant HASH_ADDR driven to the core
//   mem_sel               1 = this block owns the memory port, 0 = core
//   mem_we/mem_addr/mem_wdata  memory write/read request
//   mem_rdata             synchronous read data, valid one cycle after address
// ----------------------------------------------------------------------------
module sha256_host_ctrl #(
    parameter int unsigned NUM_OF_WORDS = 40,
    parameter logic [15:0] INPUT_ADDR   = 16'h0000,
    parameter logic [15:0] HASH_ADDR    = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        core_start,
    input  logic        core_done,
    output logic [15:0] core_input_addr,
    output logic [15:0] core_hash_addr,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Padded length: message + marker word + two length words, rounded up
    // to a whole number of 16-word blocks.
    localparam int unsigned PAD_WORDS = 16 * ((NUM_OF_WORDS + 3 + 15) / 16);
    localparam int unsigned WC_W      = $clog2(PAD_WORDS + 1);

    localparam logic [WC_W-1:0] WC_LAST_MSG  = WC_W'(NUM_OF_WORDS - 1);
    localparam logic [WC_W-1:0] WC_PAD_FIRST = WC_W'(NUM_OF_WORDS);
    localparam logic [WC_W-1:0] WC_LAST      = WC_W'(PAD_WORDS - 1);
    localparam logic [31:0]     BIT_LEN      = 32'(NUM_OF_WORDS * 32);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PAD       = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_RDHASH    = 3'd6,
        ST_OUT       = 3'd7
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [WC_W-1:0] wc_r;
    logic [WC_W-1:0] wc_s;
    logic [3:0]      rc_r;
    logic [3:0]      rc_s;
    logic [2:0]      oc_r;
    logic [2:0]      oc_s;
    logic [2:0]      cap_idx_s;
    logic [2:0]      rd_idx_s;
    logic [31:0]     hreg_r [0:7];

    // Padding word for padded index idx (only meaningful for N..P-1).
    // The upper length word (P-2) is always zero since N*32 fits in 32 bits.
    function automatic logic [31:0] pad_word(input logic [WC_W-1:0] idx);
        logic [31:0] w;
        w = 32'h0000_0000;
        if (idx == WC_PAD_FIRST) begin
            w = 32'h8000_0000;
        end else if (idx == WC_LAST) begin
            w = BIT_LEN;
        end else begin
            w = 32'h0000_0000;
        end
        return w;
    endfunction

    assign core_input_addr = INPUT_ADDR;
    assign core_hash_addr  = HASH_ADDR;

    // Next-state, counter and output decode.
    always_comb begin
        state_s    = state_r;
        wc_s       = wc_r;
        rc_s       = rc_r;
        oc_s       = oc_r;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 32'h0000_0000;
        out_last   = 1'b0;
        core_start = 1'b0;
        mem_sel    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 32'h0000_0000;
        busy       = (state_r != ST_IDLE);
        // Read data arriving now belongs to the address issued last cycle.
        cap_idx_s  = 3'(rc_r - 4'd1);
        // Hold the last hash address during the final capture-only cycle.
        rd_idx_s   = rc_r[3] ? 3'd7 : rc_r[2:0];

        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    state_s = ST_LOAD;
                    wc_s    = '0;
                    rc_s    = 4'd0;
                    oc_s    = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_LOAD: begin
                mem_sel   = 1'b1;
                in_ready  = 1'b1;
                mem_addr  = INPUT_ADDR + 16'(wc_r);
                mem_wdata = in_data;
                if (in_valid) begin
                    mem_we = 1'b1;
                    wc_s   = wc_r + 1'b1;
                    if (wc_r == WC_LAST_MSG) begin
                        state_s = ST_PAD;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    mem_we = 1'b0;
                end
            end

            ST_PAD: begin
                mem_sel   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = INPUT_ADDR + 16'(wc_r);
                mem_wdata = pad_word(wc_r);
                wc_s      = wc_r + 1'b1;
                if (wc_r == WC_LAST) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_PAD;
                end
            end

            ST_START: begin
                core_start = 1'b1;
                state_s    = ST_WAIT_BUSY;
            end

            // done is high while the core idles, so first see it drop.
            ST_WAIT_BUSY: begin
                if (!core_done) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end

            ST_WAIT_DONE: begin
                if (core_done) begin
                    state_s = ST_RDHASH;
                    rc_s    = 4'd0;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end

            ST_RDHASH: begin
                mem_sel  = 1'b1;
                mem_addr = HASH_ADDR + 16'(rd_idx_s);
                rc_s     = rc_r + 4'd1;
                if (rc_r == 4'd8) begin
                    state_s = ST_OUT;
                    oc_s    = 3'd0;
                end else begin
                    state_s = ST_RDHASH;
                end
            end

            ST_OUT: begin
                out_valid = 1'b1;
                out_data  = hreg_r[oc_r];
                out_last  = (oc_r == 3'd7);
                if (out_ready) begin
                    if (oc_r == 3'd7) begin
                        state_s = ST_IDLE;
                    end else begin
                        oc_s = oc_r + 3'd1;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wc_r    <= '0;
            rc_r    <= 4'd0;
            oc_r    <= 3'd0;
        end else begin
            state_r <= state_s;
            wc_r    <= wc_s;
            rc_r    <= rc_s;
            oc_r    <= oc_s;
        end
    end

    // Hash capture: one word per cycle during RDHASH cycles 1..8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                hreg_r[i] <= 32'h0000_0000;
            end
        end else if (state_r == ST_RDHASH && rc_r != 4'd0) begin
            hreg_r[cap_idx_s] <= mem_rdata;
        end
    end

endmodule
